csr_trap_ctrl: RTL and testbench
================================

// Module: csr_trap_ctrl
// PURPOSE
//  M-mode trap sequencer. Picks one of: exception, pending interrupt, or mret.
//  Drains the pipeline, then updates the machine CSRs through the single CSR
//  write port, one CSR per cycle, and redirects fetch to the trap handler or to mepc.
// PARAMETERS
//  XLEN        32  data width; only 32 is supported
//  VECTOR_EN   1   1: honour mtvec MODE=1 (vectored) for interrupts; 0: always direct
// PORTS
//  clk            in   1     clock
//  rst            in   1     asynchronous active-high reset
//  exc_valid      in   1     exception at commit; held until trap_ack
//  exc_code       in   4     mcause exception code (0..15)
//  exc_pc         in   32    PC of the faulting instruction
//  exc_tval       in   32    mtval value for the exception
//  mret_valid     in   1     mret at commit; held until trap_ack
//  next_pc        in   32    resume PC for an interrupt (next instruction to commit)
//  mip            in   32    current mip
//  mie            in   32    current mie
//  mstatus_rd     in   32    current mstatus
//  mtvec_rd       in   32    current mtvec
//  mepc_rd        in   32    current mepc
//  pipe_drained   in   1     pipeline empty and no stores outstanding
//  trap_ack       out  1     1-cycle pulse when a request is accepted
//  flush_req      out  1     stall fetch and kill younger instructions
//  busy           out  1     FSM not in IDLE
//  csr_we         out  1     CSR write strobe
//  csr_waddr      out  12    CSR address: 0x300 mstatus, 0x341 mepc, 0x342 mcause, 0x343 mtval
//  csr_wdata      out  32    CSR write data
//  redirect_valid out  1     1-cycle fetch redirect
//  redirect_pc    out  32    redirect target
// BEHAVIOUR
//  Reset: state = IDLE; every output is 0; capture registers are cleared.
//  Reset is async and may arrive mid-sequence. Any CSR writes already issued
//  stay in place; no redirect is issued.
//  Interrupt pending (int_pend): mstatus.MIE(3) & |(mip & mie & 12'h888).
//  Interrupt priority: MEI(11) > MSI(3) > MTI(7).
//  Arbitration, evaluated in IDLE only: exc_valid > mret_valid > int_pend.
//  - Requests that arrive while busy are ignored; requesters hold them.
//  - Interrupts are re-evaluated in IDLE after the sequence finishes.
//  Acceptance cycle T:
//  - trap_ack = 1.
//  - Capture: kind, cause = {int, 27'b0, code}, epc (exc_pc or next_pc),
//    tval (exc_tval, or 0 for interrupts).
//  - Go to FLUSH.
//  FLUSH: flush_req = 1; wait here until pipe_drained = 1.
//  - trap path -> WR_EPC.
//  - mret path -> MRET_ST.
//  flush_req stays 1 from FLUSH through REDIRECT inclusive.
//  WR_EPC   : csr_we, addr 0x341, data = epc & ~32'h3.
//  WR_CAUSE : csr_we, addr 0x342, data = cause.
//  WR_TVAL  : csr_we, addr 0x343, data = tval.
//  WR_ST    : csr_we, addr 0x300, data = mstatus_rd with MPIE(7) = MIE(3),
//             MIE = 0, MPP[12:11] = 2'b11.
//  MRET_ST  : csr_we, addr 0x300, data = mstatus_rd with MIE = MPIE,
//             MPIE = 1, MPP = 2'b11.
//  REDIRECT : redirect_valid = 1 for one cycle, then IDLE.
//  - Trap target base = {mtvec_rd[31:2], 2'b00}.
//  - Vectored interrupt (VECTOR_EN & mtvec[1:0] == 1): base + (code << 2),
//    computed mod 2^32.
//  - mret target = mepc_rd & ~32'h3, sampled in REDIRECT.
//  Latency with pipe_drained already 1:
//  - trap: ack at T, redirect at T+6.
//  - mret: ack at T, redirect at T+3.
//  csr_we is 0 in IDLE, FLUSH and REDIRECT. At most one CSR is written per cycle.
//  mtvec[1:0] values 2 and 3 are treated as direct.
// TESTING
//  1. exc_valid, code 2, exc_pc 0x100, tval 0xDEAD, mtvec 0x8000, drained.
//     -> writes mepc 0x100, mcause 0x2, mtval 0xDEAD, mstatus (MIE=0, MPP=3);
//     redirect 0x8000 at T+6.
//  2. MIE=1, mip = mie = 0x880, mtvec 0x8001, next_pc 0x204.
//     -> MEI is chosen: mcause 0x8000000B, mtval 0, mepc 0x204,
//     redirect 0x802C.
//  3. mret_valid, mstatus MPIE=1 MIE=0, mepc 0x3002.
//     -> mstatus MIE=1 MPIE=1; redirect 0x3000 at T+3.
//  4. exc_valid, mret_valid and an interrupt all at T.
//     -> only the exception is taken. mret is accepted in the first IDLE cycle
//     after the trap's redirect; the interrupt is masked by MIE=0.
//  5. pipe_drained held 0 for 5 cycles.
//     -> stays in FLUSH with csr_we = 0; the first CSR write is 1 cycle after
//     pipe_drained rises.
//  6. rst asserted during WR_CAUSE.
//     -> all outputs 0 immediately; IDLE after release; no redirect_valid.

Source files
------------

// File: rtl/csr_trap_ctrl_if.sv
// Bundle between the M-mode trap sequencer and the core / CSR file.
// The master drives trap requests and current CSR values; the slave
// (the sequencer) answers with ack/flush/busy, the CSR write port and
// the fetch redirect.
interface csr_trap_ctrl_if;
  // requests and context from commit
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic [31:0] next_pc;
  // current machine CSR values
  logic [31:0] mip;
  logic [31:0] mie;
  logic [31:0] mstatus_rd;
  logic [31:0] mtvec_rd;
  logic [31:0] mepc_rd;
  logic        pipe_drained;
  // sequencer responses
  logic        trap_ack;
  logic        flush_req;
  logic        busy;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_tval, mret_valid, next_pc,
    output mip, mie, mstatus_rd, mtvec_rd, mepc_rd, pipe_drained,
    input  trap_ack, flush_req, busy, csr_we, csr_waddr, csr_wdata,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_tval, mret_valid, next_pc,
    input  mip, mie, mstatus_rd, mtvec_rd, mepc_rd, pipe_drained,
    output trap_ack, flush_req, busy, csr_we, csr_waddr, csr_wdata,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_trap_ctrl.sv
// M-mode trap sequencer.
// In IDLE it picks exception > mret > pending interrupt, acknowledges the
// winner, holds the pipeline in flush until it has drained, writes the
// machine CSRs one per cycle through the single write port and finally
// redirects fetch to the trap handler (or to mepc for mret).
// Only XLEN = 32 is supported.
module csr_trap_ctrl #(
  parameter int XLEN      = 32,
  parameter bit VECTOR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  csr_trap_ctrl_if.slave bus
);

  localparam logic [11:0]     CSR_MSTATUS = 12'h300;
  localparam logic [11:0]     CSR_MEPC    = 12'h341;
  localparam logic [11:0]     CSR_MCAUSE  = 12'h342;
  localparam logic [11:0]     CSR_MTVAL   = 12'h343;
  // MEI(11), MTI(7), MSI(3) are the only interrupt sources handled here
  localparam logic [XLEN-1:0] IRQ_MASK    = {{(XLEN-12){1'b0}}, 12'h888};
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] ZERO        = {XLEN{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FLUSH    = 3'd1,
    S_WR_EPC   = 3'd2,
    S_WR_CAUSE = 3'd3,
    S_WR_TVAL  = 3'd4,
    S_WR_ST    = 3'd5,
    S_MRET_ST  = 3'd6,
    S_REDIRECT = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    K_EXC  = 2'd0,
    K_INT  = 2'd1,
    K_MRET = 2'd2
  } kind_e;

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [3:0]      code_q, code_d;

  logic [XLEN-1:0] int_en_s;
  logic            int_pend_s;
  logic [3:0]      int_code_s;

  logic            ack_s;
  logic            flush_s;
  logic            we_s;
  logic [11:0]     waddr_s;
  logic [XLEN-1:0] wdata_s;
  logic            rv_s;
  logic [XLEN-1:0] rpc_s;

  // mstatus on trap entry: MPIE <= MIE, MIE <= 0, MPP <= M.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: MIE <= MPIE, MPIE <= 1, MPP stays M (only mode implemented).
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Handler address; MODE 2/3 fall back to direct, exceptions never vector.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                   input logic            is_int,
                                                   input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = tvec & ALIGN_MASK;
    if (VECTOR_EN && is_int && (tvec[1:0] == 2'b01)) begin
      return base + {{(XLEN-6){1'b0}}, code, 2'b00};
    end else begin
      return base;
    end
  endfunction

  // Enabled-interrupt detection and fixed priority MEI > MSI > MTI.
  always_comb begin
    int_en_s   = bus.mip & bus.mie & IRQ_MASK;
    int_pend_s = bus.mstatus_rd[3] & (|int_en_s);
    if (int_en_s[11]) begin
      int_code_s = 4'd11;
    end else if (int_en_s[3]) begin
      int_code_s = 4'd3;
    end else if (int_en_s[7]) begin
      int_code_s = 4'd7;
    end else begin
      int_code_s = 4'd0;
    end
  end

  // Next-state, request capture and per-state output decode.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    tval_d  = tval_q;
    code_d  = code_q;
    ack_s   = 1'b0;
    flush_s = 1'b0;
    we_s    = 1'b0;
    waddr_s = 12'h000;
    wdata_s = ZERO;
    rv_s    = 1'b0;
    rpc_s   = ZERO;

    case (state_q)
      S_IDLE: begin
        if (bus.exc_valid) begin
          ack_s   = 1'b1;
          kind_d  = K_EXC;
          cause_d = {1'b0, {(XLEN-5){1'b0}}, bus.exc_code};
          epc_d   = bus.exc_pc;
          tval_d  = bus.exc_tval;
          code_d  = bus.exc_code;
          state_d = S_FLUSH;
        end else if (bus.mret_valid) begin
          ack_s   = 1'b1;
          kind_d  = K_MRET;
          cause_d = ZERO;
          epc_d   = ZERO;
          tval_d  = ZERO;
          code_d  = 4'd0;
          state_d = S_FLUSH;
        end else if (int_pend_s) begin
          ack_s   = 1'b1;
          kind_d  = K_INT;
          cause_d = {1'b1, {(XLEN-5){1'b0}}, int_code_s};
          epc_d   = bus.next_pc;
          tval_d  = ZERO;
          code_d  = int_code_s;
          state_d = S_FLUSH;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FLUSH: begin
        flush_s = 1'b1;
        if (bus.pipe_drained) begin
          state_d = (kind_q == K_MRET) ? S_MRET_ST : S_WR_EPC;
        end else begin
          state_d = S_FLUSH;
        end
      end

      S_WR_EPC: begin
        flush_s = 1'b1;
        we_s    = 1'b1;
        waddr_s = CSR_MEPC;
        wdata_s = epc_q & ALIGN_MASK;
        state_d = S_WR_CAUSE;
      end

      S_WR_CAUSE: begin
        flush_s = 1'b1;
        we_s    = 1'b1;
        waddr_s = CSR_MCAUSE;
        wdata_s = cause_q;
        state_d = S_WR_TVAL;
      end

      S_WR_TVAL: begin
        flush_s = 1'b1;
        we_s    = 1'b1;
        waddr_s = CSR_MTVAL;
        wdata_s = tval_q;
        state_d = S_WR_ST;
      end

      S_WR_ST: begin
        flush_s = 1'b1;
        we_s    = 1'b1;
        waddr_s = CSR_MSTATUS;
        wdata_s = mstatus_on_trap(bus.mstatus_rd);
        state_d = S_REDIRECT;
      end

      S_MRET_ST: begin
        flush_s = 1'b1;
        we_s    = 1'b1;
        waddr_s = CSR_MSTATUS;
        wdata_s = mstatus_on_mret(bus.mstatus_rd);
        state_d = S_REDIRECT;
      end

      S_REDIRECT: begin
        flush_s = 1'b1;
        rv_s    = 1'b1;
        if (kind_q == K_MRET) begin
          // mepc is read here, after any earlier CSR writes have landed
          rpc_s = bus.mepc_rd & ALIGN_MASK;
        end else begin
          rpc_s = trap_target(bus.mtvec_rd, kind_q == K_INT, code_q);
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers; async reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_EXC;
      cause_q <= ZERO;
      epc_q   <= ZERO;
      tval_q  <= ZERO;
      code_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      code_q  <= code_d;
    end
  end

  // The ack is decoded from live request inputs, so it is forced low while
  // reset is asserted to keep every output at 0 during reset.
  assign bus.trap_ack       = ack_s & ~rst;
  assign bus.flush_req      = flush_s;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.csr_we         = we_s;
  assign bus.csr_waddr      = waddr_s;
  assign bus.csr_wdata      = wdata_s;
  assign bus.redirect_valid = rv_s;
  assign bus.redirect_pc    = rpc_s;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: a transaction-level model of the
// trap sequence (request -> drain -> list of CSR writes -> redirect) is
// compared against the DUT on every cycle, with directed scenarios pinned
// by literal expectations and a randomized phase.
module tb_csr_trap_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  csr_trap_ctrl_if bus();

  csr_trap_ctrl #(.XLEN(32), .VECTOR_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: transaction kind 0 = exception, 1 = interrupt, 2 = mret
  bit          m_busy, m_drn, m_acc;
  int          m_step, m_kind;
  logic [31:0] m_cause, m_epc, m_tval;
  logic [3:0]  m_code;

  // bench-side CSR file for registers not fed back as inputs
  logic [31:0] csr_mcause, csr_mtval;
  bit          wr_pend;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  // observations of the DUT
  int          ack_cnt, rv_cnt, ack_cyc, rv_cyc, first_we_cyc;
  logic [31:0] rv_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_drn = 1'b0; m_acc = 1'b0; m_step = 0; m_kind = 0;
    m_cause = 32'h0; m_epc = 32'h0; m_tval = 32'h0; m_code = 4'h0;
  endtask

  // highest-priority enabled interrupt code, or -1
  function automatic int icode();
    logic [31:0] p;
    p = bus.mip & bus.mie;
    if (!bus.mstatus_rd[3]) return -1;
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    return -1;
  endfunction

  function automatic int n_writes();
    return (m_kind == 2) ? 1 : 4;
  endfunction

  // s-th CSR write of the current transaction as {addr, data}
  function automatic logic [43:0] wr_item(input int s);
    logic [31:0] ms;
    ms = bus.mstatus_rd;
    if (m_kind == 2)
      return {12'h300, (ms & ~32'h0000_1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h0000_1880};
    case (s)
      0:       return {12'h341, m_epc & ~32'h3};
      1:       return {12'h342, m_cause};
      2:       return {12'h343, m_tval};
      default: return {12'h300, (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h0000_1800};
    endcase
  endfunction

  function automatic logic [31:0] exp_target();
    logic [31:0] base;
    if (m_kind == 2) return bus.mepc_rd & ~32'h3;
    base = bus.mtvec_rd & ~32'h3;
    if (m_kind == 1 && bus.mtvec_rd[1:0] == 2'b01) base = base + {26'b0, m_code, 2'b00};
    return base;
  endfunction

  task automatic compare();
    bit          e_ack, e_we, e_rv;
    logic [43:0] it;
    e_ack = 1'b0; e_we = 1'b0; e_rv = 1'b0; it = 44'h0;
    if (rst) begin
      chk("rst_ack",   32'(bus.trap_ack), 32'h0);
      chk("rst_flush", 32'(bus.flush_req), 32'h0);
      chk("rst_busy",  32'(bus.busy), 32'h0);
      chk("rst_we",    32'(bus.csr_we), 32'h0);
      chk("rst_addr",  32'(bus.csr_waddr), 32'h0);
      chk("rst_data",  bus.csr_wdata, 32'h0);
      chk("rst_rv",    32'(bus.redirect_valid), 32'h0);
      chk("rst_rpc",   bus.redirect_pc, 32'h0);
    end else begin
      if (!m_busy) begin
        e_ack = bus.exc_valid | bus.mret_valid | (icode() >= 0);
      end else if (m_drn) begin
        if (m_step < n_writes()) begin
          e_we = 1'b1;
          it   = wr_item(m_step);
        end else begin
          e_rv = 1'b1;
        end
      end
      chk("trap_ack",  32'(bus.trap_ack), 32'(e_ack));
      chk("busy",      32'(bus.busy), 32'(m_busy));
      chk("flush_req", 32'(bus.flush_req), 32'(m_busy));
      chk("csr_we",    32'(bus.csr_we), 32'(e_we));
      chk("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
      if (e_we) begin
        chk("csr_waddr", 32'(bus.csr_waddr), 32'(it[43:32]));
        chk("csr_wdata", bus.csr_wdata, it[31:0]);
      end
      if (e_rv) chk("redirect_pc", bus.redirect_pc, exp_target());
    end
    if (bus.trap_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (bus.redirect_valid) begin rv_cnt++; rv_cyc = cyc; rv_pc = bus.redirect_pc; end
    if (bus.csr_we) begin
      wr_pend = 1'b1; wr_addr = bus.csr_waddr; wr_data = bus.csr_wdata;
      if (first_we_cyc < 0) first_we_cyc = cyc;
    end
  endtask

  task automatic model_step();
    int c;
    m_acc = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      c = icode();
      if (bus.exc_valid) begin
        m_kind = 0; m_cause = {28'h0, bus.exc_code}; m_epc = bus.exc_pc;
        m_tval = bus.exc_tval; m_code = bus.exc_code; m_acc = 1'b1;
      end else if (bus.mret_valid) begin
        m_kind = 2; m_acc = 1'b1;
      end else if (c >= 0) begin
        m_kind = 1; m_code = c[3:0]; m_cause = 32'h8000_0000 | 32'(c);
        m_epc = bus.next_pc; m_tval = 32'h0; m_acc = 1'b1;
      end
      if (m_acc) begin m_busy = 1'b1; m_drn = 1'b0; m_step = 0; end
    end else if (!m_drn) begin
      if (bus.pipe_drained) begin m_drn = 1'b1; m_step = 0; end
    end else begin
      if (m_step >= n_writes()) m_busy = 1'b0;
      else m_step++;
    end
  endtask

  // one clock: check at negedge, then advance model and CSR file after posedge
  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    if (wr_pend) begin
      case (wr_addr)
        12'h300: bus.mstatus_rd = wr_data;
        12'h341: bus.mepc_rd    = wr_data;
        12'h342: csr_mcause     = wr_data;
        12'h343: csr_mtval      = wr_data;
        default: ;
      endcase
      wr_pend = 1'b0;
    end
    if (m_acc) begin
      if (m_kind == 0) bus.exc_valid = 1'b0;
      else if (m_kind == 2) bus.mret_valid = 1'b0;
    end
  endtask

  task automatic run_to_rv(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (rv_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 32'(rv_cnt), 32'(target));
  endtask

  initial begin
    int base, k, rise, rv1, rv0, r;
    rst = 1'b1;
    bus.exc_valid = 1'b0; bus.exc_code = 4'h0; bus.exc_pc = 32'h0; bus.exc_tval = 32'h0;
    bus.mret_valid = 1'b0; bus.next_pc = 32'h0; bus.mip = 32'h0; bus.mie = 32'h0;
    bus.mstatus_rd = 32'h0; bus.mtvec_rd = 32'h0; bus.mepc_rd = 32'h0; bus.pipe_drained = 1'b0;
    csr_mcause = 32'h0; csr_mtval = 32'h0; wr_pend = 1'b0; wr_addr = 12'h0; wr_data = 32'h0;
    ack_cnt = 0; rv_cnt = 0; ack_cyc = 0; rv_cyc = 0; first_we_cyc = -1; rv_pc = 32'h0;
    model_reset();

    // reset: outputs 0 even with a request present
    tick();
    bus.exc_valid = 1'b1;
    tick();
    bus.exc_valid = 1'b0;
    tick();
    rst = 1'b0;

    // 1: exception, direct mtvec, drained
    base = rv_cnt;
    bus.mstatus_rd = 32'h88; bus.mtvec_rd = 32'h8000; bus.pipe_drained = 1'b1;
    bus.exc_code = 4'd2; bus.exc_pc = 32'h100; bus.exc_tval = 32'hDEAD; bus.exc_valid = 1'b1;
    run_to_rv(base + 1, 30, "t1_done");
    chk("t1_latency", 32'(rv_cyc - ack_cyc), 32'd6);
    chk("t1_pc",      rv_pc, 32'h8000);
    chk("t1_mepc",    bus.mepc_rd, 32'h100);
    chk("t1_mcause",  csr_mcause, 32'h2);
    chk("t1_mtval",   csr_mtval, 32'hDEAD);
    chk("t1_mstatus", bus.mstatus_rd, 32'h1880);

    // 2: vectored interrupt, MEI beats MTI
    base = rv_cnt;
    bus.mstatus_rd = 32'h8; bus.mip = 32'h880; bus.mie = 32'h880;
    bus.mtvec_rd = 32'h8001; bus.next_pc = 32'h204;
    run_to_rv(base + 1, 30, "t2_done");
    bus.mip = 32'h0; bus.mie = 32'h0;
    chk("t2_mcause",  csr_mcause, 32'h8000_000B);
    chk("t2_mtval",   csr_mtval, 32'h0);
    chk("t2_mepc",    bus.mepc_rd, 32'h204);
    chk("t2_pc",      rv_pc, 32'h802C);
    chk("t2_mstatus", bus.mstatus_rd, 32'h1880);

    // 3: mret
    base = rv_cnt;
    bus.mstatus_rd = 32'h80; bus.mepc_rd = 32'h3002; bus.mret_valid = 1'b1;
    run_to_rv(base + 1, 30, "t3_done");
    chk("t3_latency", 32'(rv_cyc - ack_cyc), 32'd3);
    chk("t3_pc",      rv_pc, 32'h3000);
    chk("t3_mstatus", bus.mstatus_rd, 32'h1888);

    // 4: exception + mret + interrupt together; exceptions never vector
    base = rv_cnt;
    bus.mstatus_rd = 32'h8; bus.mip = 32'h8; bus.mie = 32'h8; bus.mtvec_rd = 32'h8001;
    bus.next_pc = 32'h600;
    bus.exc_code = 4'd5; bus.exc_pc = 32'h400; bus.exc_tval = 32'h11;
    bus.exc_valid = 1'b1; bus.mret_valid = 1'b1;
    run_to_rv(base + 1, 30, "t4_trap_done");
    rv1 = rv_cyc;
    chk("t4_mcause", csr_mcause, 32'h5);
    chk("t4_pc",     rv_pc, 32'h8000);
    run_to_rv(base + 2, 30, "t4_mret_done");
    chk("t4_mret_ack", 32'(ack_cyc), 32'(rv1 + 1));
    chk("t4_mret_pc",  rv_pc, 32'h400);
    chk("t4_mcause_kept", csr_mcause, 32'h5);
    // MIE restored by mret, so the held MSI is now taken
    run_to_rv(base + 3, 30, "t4_int_done");
    bus.mip = 32'h0; bus.mie = 32'h0;
    chk("t4_int_cause", csr_mcause, 32'h8000_0003);
    chk("t4_int_pc",    rv_pc, 32'h800C);
    chk("t4_int_mepc",  bus.mepc_rd, 32'h600);

    // 5: drain held off for 5 cycles
    base = rv_cnt; k = 0;
    bus.pipe_drained = 1'b0; bus.mtvec_rd = 32'h9000;
    bus.exc_code = 4'd7; bus.exc_pc = 32'h506; bus.exc_tval = 32'h0; bus.exc_valid = 1'b1;
    r = ack_cnt;
    while (ack_cnt == r && k < 10) begin tick(); k++; end
    chk("t5_ack", 32'(ack_cnt), 32'(r + 1));
    first_we_cyc = -1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_write", 32'(first_we_cyc), 32'hFFFF_FFFF);
    bus.pipe_drained = 1'b1;
    rise = cyc;
    run_to_rv(base + 1, 30, "t5_done");
    chk("t5_first_we", 32'(first_we_cyc), 32'(rise + 1));
    chk("t5_mepc",     bus.mepc_rd, 32'h504);

    // 6: reset during WR_CAUSE
    rv0 = rv_cnt; first_we_cyc = -1; k = 0;
    bus.exc_code = 4'd9; bus.exc_pc = 32'h700; bus.exc_tval = 32'h5; bus.exc_valid = 1'b1;
    while (first_we_cyc < 0 && k < 20) begin tick(); k++; end
    chk("t6_reach_write", 32'(k), 32'd3);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_we_async",   32'(bus.csr_we), 32'h0);
    chk("t6_busy_async", 32'(bus.busy), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6_no_redirect", 32'(rv_cnt), 32'(rv0));
    chk("t6_mepc_kept",   bus.mepc_rd, 32'h700);
    chk("t6_mcause_kept", csr_mcause, 32'h7);

    // randomized phase
    for (int i = 0; i < 2500; i++) begin
      if (!m_busy && !bus.exc_valid && !bus.mret_valid) begin
        r = $urandom_range(0, 9);
        if (r == 0) bus.mstatus_rd = $urandom;
        if (r == 1) bus.mepc_rd = $urandom;
        if (r == 2) bus.mtvec_rd = $urandom;
      end
      if (!bus.exc_valid && $urandom_range(0, 7) == 0) begin
        bus.exc_code = 4'($urandom_range(0, 15));
        bus.exc_pc = $urandom; bus.exc_tval = $urandom; bus.exc_valid = 1'b1;
      end
      if (!bus.mret_valid && $urandom_range(0, 9) == 0) bus.mret_valid = 1'b1;
      if ($urandom_range(0, 15) == 0) begin
        bus.mip = $urandom; bus.mie = $urandom;
      end
      bus.next_pc = $urandom;
      bus.pipe_drained = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        bus.exc_valid = 1'b0; bus.mret_valid = 1'b0;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
